// File: rtl/vga_sync_decoder.sv
// ============================================================================
// Module      : vga_sync_decoder
// Description : Recovers x/y pixel position from hsync/vsync. Lock is declared
//               after LOCK_FRAMES consecutive aligned frames. Optional
//               saturating error counter: define VGA_SYNC_DECODER_ERRCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_decoder #(
  parameter int H_DISPLAY     = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_TOTAL       = 800,
  parameter int V_DISPLAY     = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_TOTAL       = 525,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       locked,
  output logic       frame_start,
  output logic       line_err,
  output logic       frame_err,
  output logic [7:0] err_count
);

  localparam int WD_W = $clog2(2 * H_TOTAL + 1);
  localparam int GF_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0]      C_HMAX     = 10'(H_TOTAL - 1);
  localparam logic [9:0]      C_VMAX     = 10'(V_TOTAL - 1);
  localparam logic [9:0]      C_HS_START = 10'(H_DISPLAY + H_FRONT_PORCH);
  localparam logic [9:0]      C_HS_LOAD  = 10'(H_DISPLAY + H_FRONT_PORCH + 1);
  localparam logic [9:0]      C_VS_START = 10'(V_DISPLAY + V_FRONT_PORCH);
  localparam logic [9:0]      C_H_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0]      C_V_DISP   = 10'(V_DISPLAY);
  localparam logic [WD_W-1:0] C_WD_LIMIT = WD_W'(2 * H_TOTAL);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_H_ALIGN = 2'd1,
    ST_V_ALIGN = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_hs_q;
  logic              r_vs_q;
  logic [9:0]        r_hcnt;
  logic [9:0]        r_vcnt;
  logic [GF_W-1:0]   r_good_frames;
  logic [GF_W-1:0]   w_good_frames_nxt;
  logic              r_v_seen;
  logic              w_v_seen_nxt;
  logic [WD_W-1:0]   r_wdog;
  logic              r_line_err;
  logic              r_frame_err;
  logic              w_line_err_nxt;
  logic              w_frame_err_nxt;

  logic              w_hs_fall;
  logic              w_vs_fall;
  logic              w_h_wrap;
  logic [9:0]        w_vcnt_inc;
  logic              w_line_good;
  logic              w_frame_good;
  logic              w_line_bad;
  logic              w_wd_trip;

  assign w_hs_fall    = !hsync_in && r_hs_q;
  assign w_vs_fall    = !vsync_in && r_vs_q;
  assign w_h_wrap     = (r_hcnt == C_HMAX);
  assign w_vcnt_inc   = w_h_wrap ? ((r_vcnt == C_VMAX) ? 10'd0 : r_vcnt + 10'd1) : r_vcnt;
  assign w_line_good  = (r_hcnt == C_HS_START);
  // Frame alignment is judged on the line count as it will be after this cycle's wrap.
  assign w_frame_good = (w_vcnt_inc == C_VS_START);
  assign w_line_bad   = w_hs_fall && !w_line_good;
  assign w_wd_trip    = (r_wdog == C_WD_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs_q <= 1'b0;
      r_vs_q <= 1'b0;
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
      r_wdog <= '0;
    end else begin
      r_hs_q <= hsync_in;
      r_vs_q <= vsync_in;
      if (w_hs_fall)
        r_hcnt <= C_HS_LOAD;
      else if (w_h_wrap)
        r_hcnt <= 10'd0;
      else
        r_hcnt <= r_hcnt + 10'd1;
      r_vcnt <= w_vs_fall ? C_VS_START : w_vcnt_inc;
      if (w_hs_fall)
        r_wdog <= '0;
      else if (!w_wd_trip)
        r_wdog <= r_wdog + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_SEARCH;
      r_good_frames <= '0;
      r_v_seen      <= 1'b0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_good_frames <= w_good_frames_nxt;
      r_v_seen      <= w_v_seen_nxt;
      r_line_err    <= w_line_err_nxt;
      r_frame_err   <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_good_frames_nxt = r_good_frames;
    w_v_seen_nxt      = r_v_seen;
    w_line_err_nxt    = 1'b0;
    w_frame_err_nxt   = 1'b0;

    case (r_state)
      ST_SEARCH: begin
        if (w_hs_fall)
          w_state_nxt = ST_H_ALIGN;
      end

      ST_H_ALIGN: begin
        if (w_hs_fall) begin
          if (w_line_good) begin
            w_state_nxt       = ST_V_ALIGN;
            w_good_frames_nxt = '0;
            w_v_seen_nxt      = 1'b0;
          end else begin
            w_line_err_nxt = 1'b1;
          end
        end
      end

      ST_V_ALIGN: begin
        // The first vsync only establishes the line count; it is not judged.
        w_line_err_nxt  = w_line_bad;
        w_frame_err_nxt = w_vs_fall && r_v_seen && !w_frame_good;
        if (w_line_err_nxt || w_frame_err_nxt) begin
          w_state_nxt       = ST_H_ALIGN;
          w_good_frames_nxt = '0;
        end else if (w_vs_fall) begin
          if (!r_v_seen) begin
            w_v_seen_nxt = 1'b1;
          end else if (int'(r_good_frames) + 1 >= LOCK_FRAMES) begin
            w_state_nxt       = ST_LOCKED;
            w_good_frames_nxt = '0;
          end else begin
            w_good_frames_nxt = r_good_frames + GF_W'(1);
          end
        end
      end

      ST_LOCKED: begin
        w_line_err_nxt  = w_line_bad;
        w_frame_err_nxt = w_vs_fall && !w_frame_good;
        if (w_line_err_nxt || w_frame_err_nxt)
          w_state_nxt = ST_SEARCH;
      end

      default: w_state_nxt = ST_SEARCH;
    endcase

    if (w_wd_trip) begin
      w_state_nxt       = ST_SEARCH;
      w_good_frames_nxt = '0;
    end
  end

  assign x           = r_hcnt;
  assign y           = r_vcnt;
  assign locked      = (r_state == ST_LOCKED);
  assign video_on    = locked && (r_hcnt < C_H_DISP) && (r_vcnt < C_V_DISP);
  assign frame_start = locked && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;

`ifdef VGA_SYNC_DECODER_ERRCNT_EN
  logic [7:0] r_err_count;
  logic [8:0] w_err_sum;

  assign w_err_sum = {1'b0, r_err_count} + {8'd0, r_line_err} + {8'd0, r_frame_err};

  always_ff @(posedge clk) begin
    if (reset)
      r_err_count <= 8'd0;
    else
      r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule

`default_nettype wire
